// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory signal bundle for dmem_access_ctrl.
// The slave modport is the controller's view; master is the core/memory side.
interface dmem_access_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_req_valid;
  logic                  out_req_ready;
  logic                  in_req_we;
  logic [2:0]            in_req_funct3;
  logic [DATA_WIDTH-1:0] in_req_addr;
  logic [DATA_WIDTH-1:0] in_req_wdata;
  logic                  out_resp_valid;
  logic [DATA_WIDTH-1:0] out_resp_rdata;
  logic                  out_resp_err;
  logic [DATA_WIDTH-1:0] out_mem_addr;
  logic [DATA_WIDTH-1:0] out_mem_data;
  logic                  out_mem_wr_en;
  logic [DATA_WIDTH-1:0] in_mem_data;

  modport master (
    output in_req_valid, in_req_we, in_req_funct3, in_req_addr, in_req_wdata, in_mem_data,
    input  out_req_ready, out_resp_valid, out_resp_rdata, out_resp_err,
           out_mem_addr, out_mem_data, out_mem_wr_en
  );

  modport slave (
    input  in_req_valid, in_req_we, in_req_funct3, in_req_addr, in_req_wdata, in_mem_data,
    output out_req_ready, out_resp_valid, out_resp_rdata, out_resp_err,
           out_mem_addr, out_mem_data, out_mem_wr_en
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store controller for a byte-addressed 64-bit memory: read-modify-write for
// narrow stores, extended loads, and error responses that never touch memory.
module dmem_access_ctrl #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] MEM_BYTES  = 64'd1048577
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  dmem_access_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  we_r;
  logic [2:0]            funct3_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  hs_s;
  logic                  req_err_s;

  logic [DATA_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [DATA_WIDTH-1:0] mem_data_r, mem_data_nxt_s;
  logic                  mem_wr_en_r, mem_wr_en_nxt_s;
  logic                  resp_valid_r, resp_valid_nxt_s;
  logic                  resp_err_r, resp_err_nxt_s;
  logic [DATA_WIDTH-1:0] resp_rdata_r, resp_rdata_nxt_s;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] mask;
    mask = (DATA_WIDTH'(1) << f3[1:0]) - DATA_WIDTH'(1);
    // Every access spans 8 bytes of memory, so the range limit ignores size.
    return ((addr & mask) != {DATA_WIDTH{1'b0}}) ||
           (addr > (MEM_BYTES - 64'd8)) ||
           (!we && (f3 == 3'b111)) ||
           (we && f3[2]);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  r = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b010:  r = {{(DATA_WIDTH-32){d[31]}}, d[31:0]};
      3'b011:  r = d;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      3'b110:  r = {{(DATA_WIDTH-32){1'b0}}, d[31:0]};
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [1:0] sz,
                                                        input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] r;
    case (sz)
      2'b00:   r = {old[DATA_WIDTH-1:8], wd[7:0]};
      2'b01:   r = {old[DATA_WIDTH-1:16], wd[15:0]};
      2'b10:   r = {old[DATA_WIDTH-1:32], wd[31:0]};
      2'b11:   r = wd;
      default: r = wd;
    endcase
    return r;
  endfunction

  assign hs_s      = (state_r == ST_IDLE) && bus.in_req_valid;
  // Evaluated on the values being latched this edge, so errors answer one cycle later.
  assign req_err_s = req_error(bus.in_req_we, bus.in_req_funct3, bus.in_req_addr);

  assign bus.out_req_ready  = (state_r == ST_IDLE) && in_rst_n;
  assign bus.out_resp_valid = resp_valid_r;
  assign bus.out_resp_err   = resp_err_r;
  assign bus.out_resp_rdata = resp_rdata_r;
  assign bus.out_mem_addr   = mem_addr_r;
  assign bus.out_mem_data   = mem_data_r;
  assign bus.out_mem_wr_en  = mem_wr_en_r;

  // Request latch, loaded on the accepting edge.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      wdata_r  <= {DATA_WIDTH{1'b0}};
    end else if (hs_s) begin
      we_r     <= bus.in_req_we;
      funct3_r <= bus.in_req_funct3;
      wdata_r  <= bus.in_req_wdata;
    end else begin
      we_r     <= we_r;
      funct3_r <= funct3_r;
      wdata_r  <= wdata_r;
    end
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = req_err_s ? ST_RESP : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ:  state_nxt_s = we_r ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the read data doubles as the merge buffer.
  always_comb begin
    mem_addr_nxt_s   = mem_addr_r;
    mem_data_nxt_s   = mem_data_r;
    mem_wr_en_nxt_s  = 1'b0;
    resp_valid_nxt_s = 1'b0;
    resp_err_nxt_s   = 1'b0;
    resp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (hs_s && req_err_s) begin
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = 1'b1;
        end else if (hs_s) begin
          mem_addr_nxt_s = bus.in_req_addr;
        end else begin
          mem_addr_nxt_s = mem_addr_r;
        end
      end
      ST_READ: begin
        if (we_r) begin
          mem_data_nxt_s  = store_merge(funct3_r[1:0], bus.in_mem_data, wdata_r);
          mem_wr_en_nxt_s = 1'b1;
        end else begin
          resp_valid_nxt_s = 1'b1;
          resp_rdata_nxt_s = load_extend(funct3_r, bus.in_mem_data);
        end
      end
      ST_WRITE: resp_valid_nxt_s = 1'b1;
      ST_RESP:  resp_valid_nxt_s = 1'b0;
      default:  resp_valid_nxt_s = 1'b0;
    endcase
  end

  // Output registers; the async clear drops the write strobe without waiting for a clock.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mem_addr_r   <= {DATA_WIDTH{1'b0}};
      mem_data_r   <= {DATA_WIDTH{1'b0}};
      mem_wr_en_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      mem_addr_r   <= mem_addr_nxt_s;
      mem_data_r   <= mem_data_nxt_s;
      mem_wr_en_r  <= mem_wr_en_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_err_r   <= resp_err_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a byte-array reference model predicts each
// response and memory write; monitors compare them as the DUT presents them.
module tb_dmem_access_ctrl;
  localparam int          MEM_N     = 1048577;
  localparam logic [63:0] MEM_BYTES = 64'd1048577;

  logic in_clk = 1'b0;
  logic in_rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mem_ver = 0;

  dmem_access_ctrl_if #(.DATA_WIDTH(64)) bus ();

  dmem_access_ctrl #(.DATA_WIDTH(64), .MEM_BYTES(MEM_BYTES)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .bus      (bus)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; int due; } wr_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];

  bit [7:0] dmem    [MEM_N];
  bit [7:0] ref_mem [MEM_N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Memory attached to the DUT: level write applied mid-cycle, combinational read.
  always @(negedge in_clk) begin
    if (bus.out_mem_wr_en && bus.out_mem_addr <= MEM_BYTES - 64'd8) begin
      for (int i = 0; i < 8; i++) dmem[int'(bus.out_mem_addr) + i] <= bus.out_mem_data[8*i +: 8];
      mem_ver <= mem_ver + 1;
    end
  end

  always @(bus.out_mem_addr or mem_ver) begin
    logic [63:0] d;
    d = 64'd0;
    if (bus.out_mem_addr <= MEM_BYTES - 64'd8) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = dmem[int'(bus.out_mem_addr) + i];
    end
    bus.in_mem_data = d;
  end

  // Monitor: responses and writes are popped and compared as they appear.
  always @(negedge in_clk) begin
    if (in_rst_n) begin
      if (bus.out_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual=valid required=none at cyc %0d", cyc);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", bus.out_resp_rdata, e.rdata);
          chk("resp_err", {63'd0, bus.out_resp_err}, {63'd0, e.err});
          chk("resp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("idle_rdata", bus.out_resp_rdata, 64'd0);
        chk("idle_err", {63'd0, bus.out_resp_err}, 64'd0);
      end
      if (bus.out_mem_wr_en) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wr_en actual=1 required=0 addr=%h at cyc %0d", bus.out_mem_addr, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", bus.out_mem_addr, w.addr);
          chk("wr_data", bus.out_mem_data, w.data);
          chk("wr_cycle", 64'(cyc), 64'(w.due));
        end
      end
    end
  end

  // Reference model: predicts the outcome of a request accepted at the next posedge.
  task automatic model_push(input logic we, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] wd);
    int          size;
    logic        err;
    logic [63:0] v;
    resp_t       r;
    wr_t         w;
    size = 1 << f3[1:0];
    err  = (a % 64'(size) != 64'd0) || (a > MEM_BYTES - 64'd8) ||
           (!we && f3 == 3'd7) || (we && f3 >= 3'd4);
    r.err = err; r.rdata = 64'd0;
    if (err) begin
      r.due = cyc + 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      v = 64'd0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      w.addr = a; w.data = v; w.due = cyc + 2;
      wr_q.push_back(w);
      r.due = cyc + 3;
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
      if (f3 <= 3'd2 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
      r.rdata = v;
      r.due = cyc + 2;
    end
    exp_q.push_back(r);
  endtask

  // Called at a negedge; leaves in_req_valid high so callers can chain requests.
  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, output int hs);
    bit ok;
    ok = 1'b0;
    bus.in_req_we = we; bus.in_req_funct3 = f3; bus.in_req_addr = a;
    bus.in_req_wdata = wd; bus.in_req_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_req_ready) begin ok = 1'b1; break; end
      @(negedge in_clk);
    end
    hs = cyc + 1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready at cyc %0d", cyc);
      bus.in_req_valid = 1'b0;
    end else begin
      model_push(we, f3, a, wd);
      @(negedge in_clk);
    end
  endtask

  task automatic one(input logic we, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd);
    int hs;
    send(we, f3, a, wd, hs);
    bus.in_req_valid = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge in_clk);
    end
    chk("drain_resp", 64'(exp_q.size()), 64'd0);
    chk("drain_wr", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    int hs_a[4];
    int hs;
    logic [63:0] a;
    logic [2:0]  f3;
    int          sz;
    bus.in_req_valid = 1'b0; bus.in_req_we = 1'b0; bus.in_req_funct3 = 3'd0;
    bus.in_req_addr = 64'd0; bus.in_req_wdata = 64'd0;

    repeat (2) @(negedge in_clk);
    chk("rst_ready", {63'd0, bus.out_req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.out_resp_valid}, 64'd0);
    chk("rst_wr_en", {63'd0, bus.out_mem_wr_en}, 64'd0);
    chk("rst_mem_addr", bus.out_mem_addr, 64'd0);
    chk("rst_mem_data", bus.out_mem_data, 64'd0);
    in_rst_n = 1'b1;
    #1 chk("ready_after_rst", {63'd0, bus.out_req_ready}, 64'd1);
    @(negedge in_clk);

    // Directed sequence
    one(1'b1, 3'b011, 64'h100, 64'h8877665544332211);
    one(1'b0, 3'b011, 64'h100, 64'd0);
    one(1'b1, 3'b000, 64'h100, 64'hFF);
    one(1'b0, 3'b011, 64'h100, 64'd0);
    one(1'b0, 3'b000, 64'h100, 64'd0);
    one(1'b0, 3'b100, 64'h100, 64'd0);
    one(1'b1, 3'b010, 64'h200, 64'h80000000);
    one(1'b0, 3'b010, 64'h200, 64'd0);
    one(1'b0, 3'b110, 64'h200, 64'd0);
    one(1'b0, 3'b001, 64'h101, 64'd0);
    one(1'b1, 3'b011, 64'h104, 64'h1234);
    one(1'b0, 3'b011, 64'hFFFFA, 64'd0);
    one(1'b0, 3'b000, 64'hFFFFA, 64'd0);
    one(1'b0, 3'b111, 64'h100, 64'd0);
    one(1'b1, 3'b100, 64'h100, 64'h55);
    one(1'b1, 3'b000, 64'hFFFF9, 64'hA5);
    one(1'b0, 3'b000, 64'hFFFF9, 64'd0);
    one(1'b0, 3'b011, 64'hFFFF8, 64'd0);
    one(1'b1, 3'b001, 64'h200, 64'hBEEF);
    one(1'b0, 3'b001, 64'h200, 64'd0);
    one(1'b0, 3'b101, 64'h200, 64'd0);
    drain();

    // Back-to-back loads with valid held high
    for (int i = 0; i < 4; i++) send(1'b0, 3'b011, 64'h100 + 64'(8*i), 64'd0, hs_a[i]);
    bus.in_req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(hs_a[i] - hs_a[i-1]), 64'd3);
    drain();

    // Reset asserted while a store is writing
    send(1'b1, 3'b011, 64'h300, 64'hCAFEF00DDEADBEEF, hs);
    bus.in_req_valid = 1'b0;
    @(negedge in_clk);
    chk("wr_en_in_write", {63'd0, bus.out_mem_wr_en}, 64'd1);
    #2 in_rst_n = 1'b0;
    #1 chk("wr_en_async_drop", {63'd0, bus.out_mem_wr_en}, 64'd0);
    exp_q.delete();
    wr_q.delete();
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    #1 chk("ready_after_rst2", {63'd0, bus.out_req_ready}, 64'd1);
    repeat (4) @(negedge in_clk);

    // Randomized traffic, sometimes back-to-back
    for (int n = 0; n < 200; n++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      case ($urandom_range(0, 9))
        7:       a = MEM_BYTES - 64'd8 - 64'($urandom_range(0, 8));
        8:       a = MEM_BYTES - 64'd8 + 64'($urandom_range(1, 8));
        9:       a = {$urandom, $urandom};
        default: begin
          a = 64'h400 + 64'($urandom_range(0, 63));
          if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
        end
      endcase
      send(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom}, hs);
      if ($urandom_range(0, 2) == 0) begin
        bus.in_req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge in_clk);
      end
    end
    bus.in_req_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the byte-addressed 64-bit data memory. The memory has combinational reads and level-sensitive writes, and every write stores all 8 bytes starting at the given address.
- Accepts load/store requests from the core pipeline through a valid/ready handshake.
- Performs read-modify-write so that sub-doubleword stores touch only their own bytes.
- Returns loads sign- or zero-extended, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- DATA_WIDTH, 64, width of data and address buses; only 64 is supported.
- MEM_BYTES, 1048577, number of addressable memory bytes (valid byte addresses 0..MEM_BYTES-1).

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_req_valid  input  1  request present.
- out_req_ready  output  1  controller can accept a request.
- in_req_we  input  1  1 = store, 0 = load.
- in_req_funct3  input  3  RV64 size code. Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- in_req_addr  input  DATA_WIDTH  byte address.
- in_req_wdata  input  DATA_WIDTH  store operand; low bytes are used.
- out_resp_valid  output  1  one-cycle completion pulse.
- out_resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
- out_resp_err  output  1  valid with out_resp_valid; 1 = misaligned, out-of-range, or illegal funct3.
- out_mem_addr  output  DATA_WIDTH  memory address.
- out_mem_data  output  DATA_WIDTH  memory write data.
- out_mem_wr_en  output  1  memory write enable.
- in_mem_data  input  DATA_WIDTH  memory read data (combinational from out_mem_addr).

Behaviour:
- Reset (async, in_rst_n=0): state IDLE.
  - All outputs 0, except out_req_ready=1 once reset is released.
  - out_mem_wr_en drops immediately on reset assertion.
  - Any in-flight request is discarded with no response.
- All memory-side outputs are registered. out_mem_wr_en is never driven combinationally, so no glitch reaches the level-sensitive write.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - out_req_ready=1. Handshake occurs when in_req_valid=1 at a rising edge.
  - On handshake, latch we, funct3, addr, wdata.
  - Error check, done on the latched request:
    - Size = 1/2/4/8 bytes from funct3[1:0].
    - Misaligned when addr mod size is not 0.
    - Out-of-range when addr > MEM_BYTES-8, because the memory always spans 8 bytes.
    - Illegal when a load has funct3=111 or a store has funct3[2]=1.
  - On error, go to RESP with err=1 and drive no memory activity. Otherwise go to READ.
- READ:
  - out_mem_addr = latched addr, out_mem_wr_en=0.
  - Capture in_mem_data into the read buffer at the end of the cycle.
  - Load goes to RESP; store goes to WRITE.
- WRITE:
  - out_mem_addr is unchanged.
  - out_mem_data = merge of the buffer and wdata:
    - SB replaces bits [7:0].
    - SH replaces bits [15:0].
    - SW replaces bits [31:0].
    - SD replaces all 64 bits.
    - All other bits are taken unchanged from the buffer.
  - out_mem_wr_en=1 for exactly this one cycle, with address and data stable throughout. Then go to RESP.
- RESP:
  - out_resp_valid=1 for one cycle, then return to IDLE. out_req_ready=0 in every state except IDLE.
  - Load data is taken from the low bits of the buffer:
    - LB/LH/LW sign-extend bit 7/15/31.
    - LBU/LHU/LWU zero-extend.
    - LD passes all 64 bits.
- Latency from the handshake edge:
  - Load response 2 cycles later.
  - Store response 3 cycles later.
  - Error response 1 cycle later.
- Back-to-back: a new request can be accepted on the cycle after RESP. No pipelining; exactly one request is outstanding at a time.
- Requests presented while out_req_ready=0 are ignored. The requester holds them until accepted.
- out_resp_rdata and out_resp_err are 0 whenever out_resp_valid=0.

Test Plan:
- Reset, then SD addr 0x100 wdata 0x8877665544332211 -> wr_en high exactly 1 cycle at handshake+2 with out_mem_data=0x8877665544332211. Then LD 0x100 -> resp at handshake+2, rdata 0x8877665544332211, err=0.
- After that SD, SB addr 0x100 wdata 0xFF -> out_mem_data 0x88776655443322FF. Then LB 0x100 -> 0xFFFFFFFFFFFFFFFF and LBU 0x100 -> 0x00000000000000FF.
- SW addr 0x200 wdata 0x80000000 over prior 0x0 -> LW 0x200 returns 0xFFFFFFFF80000000 and LWU returns 0x0000000080000000.
- LH addr 0x101, SD addr 0x104, LD addr 0xFFFFA (> MEM_BYTES-8), and load funct3=111 -> each gives resp at handshake+1 with err=1, rdata=0, and wr_en never asserted.
- Store in flight with in_rst_n pulled low during WRITE -> out_mem_wr_en falls immediately with no clock edge, no resp_valid follows, and out_req_ready=1 after release.
- in_req_valid held high with 4 queued loads -> out_req_ready pulses once per transaction, loads are accepted every 3 cycles, and responses appear in order.
